lvg_feeder: RTL

- Upstream command/operand feeder for the 4x4 fp32 matrix unit `lvg`.
- Accepts a 32-bit word stream through a valid/ready handshake and assembles 16-word matrices into the L, R and A operand banks.
- Drives the `lvg` instruction code and holds it for the unit's fixed pipeline latency.
- At the end of that latency, captures the 16-element result bus and signals completion. This replaces hand-sequenced testbench stimulus with a reusable front end.

---
 rtl/lvg_feeder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/lvg_feeder.sv
// Operand/command front end for the 4x4 fp32 matrix unit lvg: assembles L/R/A banks
// from a valid/ready word stream, holds the opcode for the unit latency, then captures the result.
module lvg_feeder #(
  parameter int unsigned LATENCY = 15,
  parameter int unsigned DW      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [16*DW-1:0]     l_flat,
  output logic [16*DW-1:0]     r_flat,
  output logic [16*DW-1:0]     a_flat,
  output logic [7:0]           instr,
  input  logic [16*DW-1:0]     b_flat,
  output logic [16*DW-1:0]     result,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned NEL = 16;
  localparam int unsigned FW  = NEL * DW;
  localparam int unsigned CW  = 4;
  localparam int unsigned LW  = 8;
  localparam int unsigned OPW = 8;
  localparam int unsigned OW  = 9;

  localparam logic [CW-1:0]  CNT_LAST = CW'(NEL - 1);
  localparam logic [LW-1:0]  LAT_LAST = LW'(LATENCY - 1);

  localparam logic [1:0] DEST_NONE = 2'd0;
  localparam logic [1:0] DEST_L    = 2'd1;
  localparam logic [1:0] DEST_R    = 2'd2;
  localparam logic [1:0] DEST_A    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [LW-1:0]    r_lat;
  logic [LW-1:0]    w_lat_nxt;
  logic [OPW-1:0]   r_opcode;
  logic [OPW-1:0]   w_opcode_nxt;
  logic [1:0]       r_dest;
  logic [1:0]       w_dest_nxt;
  logic             w_capture;
  logic             w_bank_we;
  logic             w_xfer;
  logic [OW-1:0]    w_off;

  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;
  logic [OPW-1:0]   r_instr;
  logic [FW-1:0]    r_l;
  logic [FW-1:0]    r_r;
  logic [FW-1:0]    r_a;
  logic [FW-1:0]    r_result;

  assign w_xfer = in_valid && r_in_ready;
  assign w_off  = OW'(r_cnt) * OW'(DW);

  // State register and control counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_lat    <= '0;
      r_opcode <= '0;
      r_dest   <= DEST_NONE;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_lat    <= w_lat_nxt;
      r_opcode <= w_opcode_nxt;
      r_dest   <= w_dest_nxt;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_lat_nxt    = r_lat;
    w_opcode_nxt = r_opcode;
    w_dest_nxt   = r_dest;
    w_capture    = 1'b0;
    w_bank_we    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_opcode_nxt = in_data[7:0];
          w_dest_nxt   = in_data[9:8];
          w_cnt_nxt    = '0;
          w_lat_nxt    = '0;
          if (in_data[9:8] != DEST_NONE) begin
            w_state_nxt = S_LOAD;
          end else if (in_data[7:0] != '0) begin
            w_state_nxt = S_EXEC;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          w_bank_we = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_lat_nxt   = '0;
            w_state_nxt = (r_opcode != '0) ? S_EXEC : S_DONE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_EXEC: begin
        if (r_lat == LAT_LAST) begin
          w_capture   = 1'b1;
          w_lat_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_lat_nxt = r_lat + LW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered handshake/status outputs, decoded from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_instr    <= '0;
    end else begin
      r_in_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
      r_instr    <= (w_state_nxt == S_EXEC) ? w_opcode_nxt : '0;
    end
  end

  // Operand banks: one element written per accepted payload word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_l <= '0;
      r_r <= '0;
      r_a <= '0;
    end else if (w_bank_we) begin
      unique case (r_dest)
        DEST_L:  r_l[w_off +: DW] <= in_data;
        DEST_R:  r_r[w_off +: DW] <= in_data;
        DEST_A:  r_a[w_off +: DW] <= in_data;
        default: begin
        end
      endcase
    end
  end

  // Result capture on the edge leaving EXEC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result <= '0;
    end else if (w_capture) begin
      r_result <= b_flat;
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign instr    = r_instr;
  assign l_flat   = r_l;
  assign r_flat   = r_r;
  assign a_flat   = r_a;
  assign result   = r_result;

endmodule
